// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 receiver:
//                receive FSM state encoding, scan-code prefix bytes and
//                frame bit counts.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Receive FSM states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } ps2_state_e;

    // Scan-code prefix bytes
    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    // Frame: start, 8 data bits, parity, stop
    localparam int PS2_FRAME_BITS = 11;

    // Index of the stop bit counted from the first bit after start
    localparam int PS2_STOP_IDX   = PS2_FRAME_BITS - 2;

endpackage
`default_nettype wire

// File: rtl/ps2_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_fifo
//  Description : Synchronous FIFO with wrap-bit pointers for exact
//                full/empty tracking.
//  Ports       : clk, clrn (async active-low reset)
//                push/wdata  - write request and data
//                pop         - read request (ignored when empty)
//                rdata       - head entry, combinational
//                full/empty  - occupancy flags
//                level       - number of occupied entries
//  Notes       : A push while full is accepted only if a pop completes in
//                the same cycle; otherwise it is dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign level   = wptr - rptr;
    assign do_pop  = pop & ~empty;
    // When full, a simultaneous pop frees the head slot that is overwritten
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx
//  Description : PS/2 device-to-host receiver. Synchronises the PS/2 pins,
//                deframes 11-bit frames with odd parity, aborts stalled
//                frames, and queues bytes in a FIFO.
//  Ports       : clk, clrn         - system clock, async active-low reset
//                ps2_clk, ps2_data - raw PS/2 pins
//                nextdata_n        - active-low pop request
//                ovf_clr           - clears overflow
//                data/ext/brk      - head entry (combinational)
//                ready, level      - FIFO not empty / occupancy
//                overflow          - sticky dropped-byte flag
//                frame_err         - one-cycle pulse on bad/timed-out frame
//  Config      : PS2_RX_SCANDECODE_EN - fold E0/F0 prefixes into ext/brk
//                flags stored with each entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                         clk,
    input  logic                         clrn,
    input  logic                         ps2_clk,
    input  logic                         ps2_data,
    input  logic                         nextdata_n,
    input  logic                         ovf_clr,
    output logic [7:0]                   data,
    output logic                         ext,
    output logic                         brk,
    output logic                         ready,
    output logic [$clog2(FIFO_DEPTH):0]  level,
    output logic                         overflow,
    output logic                         frame_err
);

`ifdef PS2_RX_SCANDECODE_EN
    localparam int ENTRY_W = 10;
`else
    localparam int ENTRY_W = 8;
`endif
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Synchronisers plus one history flop on the clock line
    logic clk_s1, clk_s2, clk_hist;
    logic dat_s1, dat_s2;

    ps2_state_e  state, state_nx;
    logic [3:0]  bitcnt, bitcnt_nx;
    logic [8:0]  shreg, shreg_nx;     // {parity, data[7:0]} once complete
    logic [TW-1:0] tocnt, tocnt_nx;
    logic        fall;
    logic        byte_valid;
    logic        err_nx;
    logic [7:0]  rx_byte;

    logic               push_req;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head;
    logic               pop;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_hist <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_hist <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
        end
    end

    assign fall    = clk_hist & ~clk_s2;
    assign rx_byte = shreg[7:0];

    // ------------------------------------------------------------------
    // Receive FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            tocnt     <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            bitcnt    <= bitcnt_nx;
            shreg     <= shreg_nx;
            tocnt     <= tocnt_nx;
            frame_err <= err_nx;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nx   = state;
        bitcnt_nx  = bitcnt;
        shreg_nx   = shreg;
        tocnt_nx   = tocnt;
        byte_valid = 1'b0;
        err_nx     = 1'b0;
        case (state)
            IDLE: begin
                tocnt_nx  = '0;
                bitcnt_nx = '0;
                if (fall && !dat_s2) state_nx = RECV;
            end
            RECV: begin
                if (fall) begin
                    tocnt_nx = '0;
                    if (bitcnt == 4'(PS2_STOP_IDX)) begin
                        state_nx = IDLE;
                        // Odd parity: XOR over data and parity must be 1
                        if (dat_s2 && (^shreg)) byte_valid = 1'b1;
                        else                    err_nx     = 1'b1;
                    end else begin
                        // LSB first: shift in from the top
                        shreg_nx  = {dat_s2, shreg[8:1]};
                        bitcnt_nx = bitcnt + 4'd1;
                    end
                end else if (tocnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end else begin
                    tocnt_nx = tocnt + TW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Prefix decode / push generation
    // ------------------------------------------------------------------
    assign pop  = ~fifo_empty & ~nextdata_n;
    assign drop = push_req & fifo_full & ~pop;

`ifdef PS2_RX_SCANDECODE_EN
    logic pend_ext, pend_brk;
    logic pend_ext_nx, pend_brk_nx;

    always_comb begin
        push_req    = 1'b0;
        push_data   = {pend_ext, pend_brk, rx_byte};
        pend_ext_nx = pend_ext;
        pend_brk_nx = pend_brk;
        if (byte_valid) begin
            if (rx_byte == PS2_PREFIX_EXT) begin
                pend_ext_nx = 1'b1;
            end else if (rx_byte == PS2_PREFIX_BRK) begin
                pend_brk_nx = 1'b1;
            end else begin
                push_req    = 1'b1;
                pend_ext_nx = 1'b0;
                pend_brk_nx = 1'b0;
            end
        end
        // A lost frame or lost byte breaks the prefix sequence
        if (err_nx) begin
            pend_ext_nx = 1'b0;
            pend_brk_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pend_ext <= 1'b0;
            pend_brk <= 1'b0;
        end else begin
            pend_ext <= pend_ext_nx;
            pend_brk <= pend_brk_nx;
        end
    end

    assign ext  = head[9];
    assign brk  = head[8];
    assign data = head[7:0];
`else
    assign push_req  = byte_valid;
    assign push_data = rx_byte;
    assign ext       = 1'b0;
    assign brk       = 1'b0;
    assign data      = head;
`endif

    // Set wins over clear
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)        overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    ps2_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (push_req),
        .wdata (push_data),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign ready = ~fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_rx
//  Description : Self-checking bench for ps2_rx. A queue-based model of the
//                receiver (entries, prefix flags, overflow) predicts every
//                observed value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx;

    localparam int DEPTH = 8;
    localparam int TO    = 2000;
    localparam int HALF  = 40;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic       ovf_clr = 1'b0;
    logic [7:0] data;
    logic       ext;
    logic       brk;
    logic       ready;
    logic [3:0] level;
    logic       overflow;
    logic       frame_err;

    int total = 0;
    int bad   = 0;
    int err_seen = 0;

    // Reference model state
    logic [9:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;

    ps2_rx #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .ovf_clr    (ovf_clr),
        .data       (data),
        .ext        (ext),
        .brk        (brk),
        .ready      (ready),
        .level      (level),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Counts high cycles of frame_err, so a stretched pulse shows up too
    always @(negedge clk) if (frame_err === 1'b1) err_seen++;

    // ---------------- model ----------------
    task automatic model_byte(input logic [7:0] b);
`ifdef PS2_RX_SCANDECODE_EN
        if (b == 8'hE0) begin m_ext = 1'b1; return; end
        if (b == 8'hF0) begin m_brk = 1'b1; return; end
`endif
        if (q.size() == DEPTH) m_ovf = 1'b1;
        else                   q.push_back({m_ext, m_brk, b});
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic model_err();
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    task automatic send_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Sends a frame; pop_at_stop lowers nextdata_n for exactly the clk edge
    // that detects the stop-bit fall (third edge after the pin falls).
    task automatic send_frame(input logic [7:0] b, input logic bad_par,
                              input logic pop_at_stop);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 10; i++) send_bit(fr[i]);
        @(negedge clk) ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        if (pop_at_stop) begin
            @(posedge clk);
            @(posedge clk);
            @(negedge clk) nextdata_n = 1'b0;
            @(negedge clk) nextdata_n = 1'b1;
            repeat (HALF - 2) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk) nextdata_n = 1'b0;
        @(negedge clk) nextdata_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low got=%b want=0", ready); end
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
        total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", frame_err); end
    endtask

    task automatic test_single();
        int e0;
        e0 = err_seen;
        send_frame(8'h1C, 1'b0, 1'b0);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", ready); end
        total++; if ({ext, brk, data} !== 10'h01C) begin bad++; $display("FAIL single_data got=%h want=01c", {ext, brk, data}); end
        total++; if (level !== 4'd1) begin bad++; $display("FAIL single_level got=%0d want=1", level); end
        total++; if (err_seen !== e0) begin bad++; $display("FAIL single_noerr got=%0d want=%0d", err_seen, e0); end
        pop_one();
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL single_pop_ready got=%b want=0", ready); end
    endtask

    task automatic test_parity_err();
        int e0;
        e0 = err_seen;
        send_frame(8'h1C, 1'b1, 1'b0);
        total++; if (err_seen !== e0 + 1) begin bad++; $display("FAIL parity_ferr got=%0d want=%0d", err_seen - e0, 1); end
        total++; if (level !== 4'd0) begin bad++; $display("FAIL parity_level got=%0d want=0", level); end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        for (int i = 0; i < DEPTH + 1; i++) begin
            do b = 8'($urandom); while (b == 8'hE0 || b == 8'hF0);
            send_frame(b, 1'b0, 1'b0);
            model_byte(b);
        end
        total++; if (level !== 4'(DEPTH)) begin bad++; $display("FAIL ovf_level got=%0d want=%0d", level, DEPTH); end
        total++; if (overflow !== m_ovf) begin bad++; $display("FAIL ovf_flag got=%b want=%b", overflow, m_ovf); end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if ({ext, brk, data} !== q[0]) begin bad++; $display("FAIL ovf_order[%0d] got=%h want=%h", i, {ext, brk, data}, q[0]); end
            void'(q.pop_front());
            pop_one();
        end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b want=0", ready); end
        @(negedge clk) ovf_clr = 1'b1;
        @(negedge clk) ovf_clr = 1'b0;
        m_ovf = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b want=0", overflow); end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_seen;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        repeat (TO + 100) @(negedge clk);
        model_err();
        total++; if (err_seen !== e0 + 1) begin bad++; $display("FAIL timeout_ferr got=%0d want=1", err_seen - e0); end
        total++; if (level !== 4'd0) begin bad++; $display("FAIL timeout_level got=%0d want=0", level); end
        send_frame(8'h29, 1'b0, 1'b0);
        total++; if ({ready, ext, brk, data} !== 11'h429) begin bad++; $display("FAIL timeout_next got=%h want=429", {ready, ext, brk, data}); end
        pop_one();
    endtask

    task automatic test_full_push_pop();
        logic [7:0] b;
        for (int i = 0; i < DEPTH; i++) begin
            do b = 8'($urandom); while (b == 8'hE0 || b == 8'hF0);
            send_frame(b, 1'b0, 1'b0);
            model_byte(b);
        end
        do b = 8'($urandom); while (b == 8'hE0 || b == 8'hF0);
        send_frame(b, 1'b0, 1'b1);
        void'(q.pop_front());
        model_byte(b);
        total++; if (level !== 4'(DEPTH)) begin bad++; $display("FAIL fpp_level got=%0d want=%0d", level, DEPTH); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf got=%b want=0", overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if ({ext, brk, data} !== q[0]) begin bad++; $display("FAIL fpp_order[%0d] got=%h want=%h", i, {ext, brk, data}, q[0]); end
            void'(q.pop_front());
            pop_one();
        end
    endtask

    task automatic test_prefix();
        send_frame(8'hE0, 1'b0, 1'b0); model_byte(8'hE0);
        send_frame(8'hF0, 1'b0, 1'b0); model_byte(8'hF0);
        send_frame(8'h75, 1'b0, 1'b0); model_byte(8'h75);
        total++; if (level !== 4'(q.size())) begin bad++; $display("FAIL prefix_level got=%0d want=%0d", level, q.size()); end
        while (q.size() > 0) begin
            total++; if ({ext, brk, data} !== q[0]) begin bad++; $display("FAIL prefix_entry got=%h want=%h", {ext, brk, data}, q[0]); end
            void'(q.pop_front());
            pop_one();
        end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL prefix_empty got=%b want=0", ready); end
    endtask

    // Random bytes (prefix-heavy) with occasional parity errors, then a
    // back-to-back drain holding nextdata_n low.
    task automatic test_back_to_back();
        logic [7:0] b;
        logic       bp;
        int         e0;
        int         n;
        int         exp_err;
        e0 = err_seen;
        exp_err = 0;
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0: b = 8'hE0;
                1: b = 8'hF0;
                default: b = 8'($urandom);
            endcase
            bp = ($urandom_range(0, 5) == 0);
            send_frame(b, bp, 1'b0);
            if (bp) begin model_err(); exp_err++; end
            else    model_byte(b);
        end
        total++; if (err_seen !== e0 + exp_err) begin bad++; $display("FAIL b2b_ferr got=%0d want=%0d", err_seen - e0, exp_err); end
        total++; if (overflow !== m_ovf) begin bad++; $display("FAIL b2b_ovf got=%b want=%b", overflow, m_ovf); end
        total++; if (level !== 4'(q.size())) begin bad++; $display("FAIL b2b_level got=%0d want=%0d", level, q.size()); end
        n = q.size();
        @(negedge clk) nextdata_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            total++; if ({ext, brk, data} !== q[0]) begin bad++; $display("FAIL b2b_entry[%0d] got=%h want=%h", i, {ext, brk, data}, q[0]); end
            void'(q.pop_front());
            @(negedge clk);
        end
        nextdata_n = 1'b1;
        total++; if (ready !== 1'b0 || level !== 4'd0) begin bad++; $display("FAIL b2b_drained ready=%b level=%0d want 0/0", ready, level); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity_err();
        test_overflow();
        test_timeout();
        test_full_push_pop();
        test_prefix();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_rx.md
# ps2_rx

PS/2 device-to-host receiver with parametrised FIFO depth, frame timeout, error reporting and optional make/break scan-code decoding. It sits between the board PS/2 pins and the keyboard consumer logic, where keycode-to-ASCII translation takes place. It supersedes the fixed 8-entry receiver: full/empty tracking is exact, overflow drops new data, and stalled frames are aborted.

## Interface
- `FIFO_DEPTH`, default 8: FIFO entries; must be a power of two and at least 2.
- `TIMEOUT_CYCLES`, default 50000: `clk` cycles allowed between `ps2_clk` falling edges inside a frame.
- `clk`, input, 1: system clock; the only clock.
- `clrn`, input, 1: reset, asynchronous and active-low.
- `ps2_clk`, input, 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`, input, 1: raw PS/2 data.
- `nextdata_n`, input, 1: active-low pop request.
- `ovf_clr`, input, 1: synchronous clear of `overflow`.
- `data`, output, 8: scan code at the FIFO head.
- `ext`, output, 1: head entry was preceded by E0. Only with the decode macro; otherwise tied to 0.
- `brk`, output, 1: head entry was preceded by F0. Only with the decode macro; otherwise tied to 0.
- `ready`, output, 1: FIFO is not empty.
- `level`, output, $clog2(FIFO_DEPTH)+1: number of occupied entries.
- `overflow`, output, 1: sticky flag; a byte was dropped because the FIFO was full.
- `frame_err`, output, 1: one-cycle pulse on a bad frame or a timeout.

## Operation
- `ps2_clk` and `ps2_data` pass through 2-flop synchronisers.
- `ps2_clk` gets one extra history flop. A falling edge is detected when the history flop is 1 and the synchronised value is 0.
- Receive FSM:
  - IDLE → RECV on a falling edge with sampled data 0 (start bit). A falling edge with data 1 is ignored.
  - In RECV, bits are taken on falling edges: 8 data bits (LSB first), then parity, then stop. `bitcnt` runs 0..9.
  - On the stop edge: go to IDLE. The frame is valid if stop = 1 and the XOR of data and parity is 1 (odd parity). Otherwise pulse `frame_err` and discard the frame.
  - Timeout: a counter resets on every falling edge in RECV. If it reaches TIMEOUT_CYCLES-1, go to IDLE, pulse `frame_err` and discard the partial frame.
- FIFO:
  - Read and write pointers carry one extra wrap bit. Full means the indices are equal and the wrap bits differ; empty means the pointers are equal.
  - Push happens on a valid byte. If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and `overflow` is set.
  - Pop happens when `ready` is 1 and `nextdata_n` is 0, once per cycle while `nextdata_n` stays low.
  - Pop on empty is ignored.
  - Push and pop in the same cycle: both complete and `level` is unchanged. This holds when full as well, with no overflow.
- `overflow` is cleared by `ovf_clr` or reset. If set and clear coincide, set wins.
- `data`/`ext`/`brk` show the head entry combinationally. Their value while `ready` is 0 is don't-care.
- Reset values: `ready` = 0, `level` = 0, `overflow` = 0, `frame_err` = 0, pointers = 0, FSM in IDLE, prefix flags = 0. A reset mid-frame discards the partial frame.

## Timing
- Latency: the entry becomes visible (`ready` = 1, `level` incremented) on the cycle after the `clk` edge that detects the stop-bit falling edge. That detection edge comes 3 `clk` edges after the pin falls.
- Pop: the pointer advances on the sampling edge. `data` shows the next entry in the following cycle.
- `frame_err` is high for exactly one cycle, in the same cycle relation as the push.

## Configuration
- `PS2_RX_SCANDECODE_EN` defined:
  - FIFO entries are 10 bits: {`ext`, `brk`, code}.
  - A valid byte E0 sets the pending-ext flag and F0 sets the pending-brk flag; neither byte is pushed.
  - Any other byte pushes {pending-ext, pending-brk, byte} and clears both flags.
  - `frame_err` or a dropped push also clears both flags.
- `PS2_RX_SCANDECODE_EN` undefined:
  - Entries are 8 bits and every valid byte is pushed raw, including E0 and F0.
  - `ext` and `brk` are tied to 0.

## Structure
- `ps2_pkg` holds:
  - the FSM state enum (IDLE, RECV);
  - the constants PS2_PREFIX_EXT = 8'hE0 and PS2_PREFIX_BRK = 8'hF0;
  - the frame-bit count.
- Sub-module `ps2_fifo`: a synchronous FIFO with parameters for width and depth, exposing push/pop/full/empty/level.
- Synchronisers, FSM, timeout counter and prefix decode stay in `ps2_rx`.

## Test plan
- Single frame for 8'h1C with correct parity and a 40-cycle PS/2 half-period → `ready` = 1, `data` = 1C, `level` = 1. One pop → `ready` = 0.
- Frame 8'h1C with the parity bit flipped → `frame_err` pulse, `level` stays 0.
- Eight frames with no pops at FIFO_DEPTH = 8, then a ninth → `level` = 8, `overflow` = 1, the 9th byte is absent. Eight pops return the first eight in order. `ovf_clr` → `overflow` = 0.
- Hold `ps2_clk` high after 4 bits for TIMEOUT_CYCLES → `frame_err` pulse. A following good frame 8'h29 is received correctly.
- Push coinciding with a pop while full → `level` stays 8, `overflow` stays 0.
- With the macro, send E0 F0 75 → a single entry: `ext` = 1, `brk` = 1, `data` = 75. Without the macro → three entries: E0, F0, 75.
